scan_test_sequencer: RTL and testbench

- On-chip sequencer for the s5378_bench scan-test datapath: test_se, two scan chains (test_si1/test_so1, test_si2/test_so2) and the DUT clock enable.
- Consumes a streamed pattern set and applies each pattern as shift-in, SE settle, then launch-on-capture cycles.
- Compares unloaded responses against masked expected bits, counts mismatches and reports the first failing pattern.
- Replaces the external pattern-validation bench for at-speed (SDD) pattern replay in silicon bring-up.

---
 rtl/scan_seq_pkg.sv | 29 ++
 rtl/scan_cmp_unit.sv | 71 +++++++
 rtl/scan_test_sequencer.sv | 177 +++++++++++++++++
 tb/tb_scan_test_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan test sequencer.
// Optional feature macro: SCAN_SIG_EN (adds the 32-bit response MISR).
package scan_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SETTLE_IN,
      CAPTURE,
      SETTLE_OUT,
      FINISH
   } seq_state_t;

`ifdef SCAN_SIG_EN
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
`endif

   // Wide enough for any PAT_W; users truncate to their own width
   localparam logic [63:0] FIRST_FAIL_RST = '1;

   // Minimum counter width able to hold values 0..value-1 (at least 1 bit)
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/scan_cmp_unit.sv
// Masked 2-chain response compare, saturating mismatch counter,
// first-failing-pass capture and (with SCAN_SIG_EN) a 32-bit MISR.
module scan_cmp_unit
   import scan_seq_pkg::*;
#(
   parameter int PAT_W  = 16,
   parameter int FAIL_W = 16
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              beat_en,
   input  logic [1:0]        so,
   input  logic [1:0]        exp_bits,
   input  logic [1:0]        msk,
   input  logic [PAT_W-1:0]  pat_idx,
   output logic [FAIL_W-1:0] fail_cnt,
   output logic [PAT_W-1:0]  first_fail_pat,
   output logic              fail_seen
`ifdef SCAN_SIG_EN
   ,
   output logic [31:0]       sig
`endif
);

   logic [1:0]      miss;
   logic [1:0]      miss_num;
   logic [FAIL_W:0] cnt_sum;

   assign miss     = msk & (so ^ exp_bits);
   assign miss_num = {1'b0, miss[0]} + {1'b0, miss[1]};
   assign cnt_sum  = {1'b0, fail_cnt} + {{(FAIL_W - 1){1'b0}}, miss_num};

   // Accumulate mismatches on accepted beats; the carry-out saturates the count
   always_ff @(posedge clock) begin
      if (reset) begin
         fail_cnt       <= '0;
         fail_seen      <= 1'b0;
         first_fail_pat <= PAT_W'(FIRST_FAIL_RST);
      end else if (clear) begin
         fail_cnt       <= '0;
         fail_seen      <= 1'b0;
         first_fail_pat <= PAT_W'(FIRST_FAIL_RST);
      end else if (beat_en) begin
         if (cnt_sum[FAIL_W]) begin
            fail_cnt <= '1;
         end else begin
            fail_cnt <= cnt_sum[FAIL_W-1:0];
         end
         if (!fail_seen && (|miss)) begin
            fail_seen      <= 1'b1;
            first_fail_pat <= pat_idx;
         end
      end
   end

`ifdef SCAN_SIG_EN
   // Fold raw unload bits into the signature only on beats the host cares about
   always_ff @(posedge clock) begin
      if (reset) begin
         sig <= '0;
      end else if (clear) begin
         sig <= '0;
      end else if (beat_en && (|msk)) begin
         sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ {30'h0, so};
      end
   end
`endif

endmodule

// File: rtl/scan_test_sequencer.sv
// Scan-test sequencer: streams patterns into two scan chains, runs
// settle / launch-capture / settle around each pattern and checks unloads.
// Optional feature macro: SCAN_SIG_EN (exposes the 32-bit MISR signature).
module scan_test_sequencer
   import scan_seq_pkg::*;
#(
   parameter int CHAIN_LEN     = 90,
   parameter int PAT_W         = 16,
   parameter int CAP_CYCLES    = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int FAIL_W        = 16
)
(
   input  logic              blif_clk_net,
   input  logic              blif_reset_net,
   input  logic              start,
   input  logic [PAT_W-1:0]  num_patterns,
   input  logic              pat_valid,
   output logic              pat_ready,
   input  logic [1:0]        pat_si,
   input  logic [1:0]        pat_exp,
   input  logic [1:0]        pat_msk,
   input  logic              test_so1,
   input  logic              test_so2,
   output logic              test_si1,
   output logic              test_si2,
   output logic              test_se,
   output logic              dut_clk_en,
   output logic              busy,
   output logic              done,
   output logic [FAIL_W-1:0] fail_cnt,
   output logic [PAT_W-1:0]  first_fail_pat,
   output logic              fail_seen
`ifdef SCAN_SIG_EN
   ,
   output logic [31:0]       sig
`endif
);

   localparam int BEAT_W  = clog2(CHAIN_LEN);
   localparam int SUB_MAX = (CAP_CYCLES > SETTLE_CYCLES) ? CAP_CYCLES : SETTLE_CYCLES;
   localparam int SUB_W   = clog2(SUB_MAX + 1);

   seq_state_t        state;
   logic [BEAT_W-1:0] beat_cnt;
   logic [SUB_W-1:0]  sub_cnt;
   logic [PAT_W-1:0]  pat_idx;
   logic [PAT_W-1:0]  pat_total;
   logic              cap_clk_en;
   logic              in_shift;
   logic              beat_ok;
   logic              run_start;

   assign in_shift   = (state == SHIFT);
   assign beat_ok    = in_shift && pat_valid;
   assign run_start  = (state == IDLE) && start;
   assign pat_ready  = in_shift;
   assign dut_clk_en = in_shift ? pat_valid : cap_clk_en;
   assign test_si1   = in_shift & pat_si[0];
   assign test_si2   = in_shift & pat_si[1];

   // Sequencer FSM; test_se, busy, done and the capture clock enable are set on
   // the transition into each state. Reset lands in IDLE, where the chains stay
   // in shift mode, so test_se comes out of reset high.
   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         sub_cnt    <= '0;
         pat_idx    <= '0;
         pat_total  <= '0;
         test_se    <= 1'b1;
         cap_clk_en <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pat_total <= num_patterns;
                  pat_idx   <= '0;
                  beat_cnt  <= '0;
                  sub_cnt   <= '0;
                  busy      <= 1'b1;
                  test_se   <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (pat_valid) begin
                  if (int'(beat_cnt) == CHAIN_LEN - 1) begin
                     beat_cnt <= '0;
                     sub_cnt  <= '0;
                     if (pat_idx < pat_total) begin
                        test_se <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                           cap_clk_en <= 1'b1;
                           state      <= CAPTURE;
                        end else begin
                           state <= SETTLE_IN;
                        end
                     end else begin
                        done  <= 1'b1;
                        state <= FINISH;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            SETTLE_IN: begin
               if (int'(sub_cnt) == SETTLE_CYCLES - 1) begin
                  sub_cnt    <= '0;
                  cap_clk_en <= 1'b1;
                  state      <= CAPTURE;
               end else begin
                  sub_cnt <= sub_cnt + SUB_W'(1);
               end
            end
            CAPTURE: begin
               if (int'(sub_cnt) == CAP_CYCLES - 1) begin
                  sub_cnt    <= '0;
                  cap_clk_en <= 1'b0;
                  test_se    <= 1'b1;
                  if (SETTLE_CYCLES == 0) begin
                     pat_idx <= pat_idx + PAT_W'(1);
                     state   <= SHIFT;
                  end else begin
                     state <= SETTLE_OUT;
                  end
               end else begin
                  sub_cnt <= sub_cnt + SUB_W'(1);
               end
            end
            SETTLE_OUT: begin
               if (int'(sub_cnt) == SETTLE_CYCLES - 1) begin
                  sub_cnt <= '0;
                  pat_idx <= pat_idx + PAT_W'(1);
                  state   <= SHIFT;
               end else begin
                  sub_cnt <= sub_cnt + SUB_W'(1);
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   scan_cmp_unit #(
      .PAT_W  (PAT_W),
      .FAIL_W (FAIL_W)
   ) u_cmp (
      .clock          (blif_clk_net),
      .reset          (blif_reset_net),
      .clear          (run_start),
      .beat_en        (beat_ok),
      .so             ({test_so2, test_so1}),
      .exp_bits       (pat_exp),
      .msk            (pat_msk),
      .pat_idx        (pat_idx),
      .fail_cnt       (fail_cnt),
      .first_fail_pat (first_fail_pat),
      .fail_seen      (fail_seen)
`ifdef SCAN_SIG_EN
      ,
      .sig            (sig)
`endif
   );

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Bench for scan_test_sequencer. Includes a behavioural model of the two scan
// chains whose capture cycle rotates each chain by one and inverts it, so two
// capture cycles leave every chain rotated by two. With SCAN_SIG_EN defined the
// signature output is also checked.
module tb_scan_test_sequencer;

   localparam int CHAIN_LEN     = 90;
   localparam int PAT_W         = 16;
   localparam int FAIL_W        = 16;
   localparam int CAP_CYCLES    = 2;
   localparam int SETTLE_CYCLES = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [PAT_W-1:0]  num_patterns = '0;
   logic              pat_valid = 1'b0;
   logic              pat_ready;
   logic [1:0]        pat_si = 2'b11;
   logic [1:0]        pat_exp = 2'b00;
   logic [1:0]        pat_msk = 2'b00;
   logic              test_so1;
   logic              test_so2;
   logic              test_si1;
   logic              test_si2;
   logic              test_se;
   logic              dut_clk_en;
   logic              busy;
   logic              done;
   logic [FAIL_W-1:0] fail_cnt;
   logic [PAT_W-1:0]  first_fail_pat;
   logic              fail_seen;
`ifdef SCAN_SIG_EN
   logic [31:0]       sig;
`endif

   int checks = 0;
   int errors = 0;
   int prev_seed = 0;
   int prev_n = 0;

   typedef struct {
      int          latency;
      int          fail_cnt;
      int          first_fail;
      int          fail_seen;
      int          se_low;
      int          cap_cyc;
      int          beats;
      int          bad_en;
      logic [31:0] sig;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   scan_test_sequencer dut (
      .blif_clk_net   (clk),
      .blif_reset_net (reset),
      .start          (start),
      .num_patterns   (num_patterns),
      .pat_valid      (pat_valid),
      .pat_ready      (pat_ready),
      .pat_si         (pat_si),
      .pat_exp        (pat_exp),
      .pat_msk        (pat_msk),
      .test_so1       (test_so1),
      .test_so2       (test_so2),
      .test_si1       (test_si1),
      .test_si2       (test_si2),
      .test_se        (test_se),
      .dut_clk_en     (dut_clk_en),
      .busy           (busy),
      .done           (done),
      .fail_cnt       (fail_cnt),
      .first_fail_pat (first_fail_pat),
      .fail_seen      (fail_seen)
`ifdef SCAN_SIG_EN
      ,
      .sig            (sig)
`endif
   );

   // Scan chain model: shift toward the last flop, rotate-and-invert on capture
   logic [CHAIN_LEN-1:0] chain1 = '0;
   logic [CHAIN_LEN-1:0] chain2 = '0;
   assign test_so1 = chain1[CHAIN_LEN-1];
   assign test_so2 = chain2[CHAIN_LEN-1];

   always @(posedge clk) begin
      if (dut_clk_en) begin
         if (test_se) begin
            chain1 <= {chain1[CHAIN_LEN-2:0], test_si1};
            chain2 <= {chain2[CHAIN_LEN-2:0], test_si2};
         end else begin
            chain1 <= ~{chain1[CHAIN_LEN-2:0], chain1[CHAIN_LEN-1]};
            chain2 <= ~{chain2[CHAIN_LEN-2:0], chain2[CHAIN_LEN-1]};
         end
      end
   end

   // Load bit for chain chn at beat `beat` of pass `pass` in run `seed`
   function automatic logic pat_bit(input int seed, input int pass, input int chn, input int beat);
      int h;
      h = seed * 31 + pass * 17 + chn * 7 + beat * beat * 3 + beat * 5;
      return h[0] ^ h[2] ^ h[4];
   endfunction

   // Unload bits expected at beat b of pass `pass`
   function automatic logic [1:0] expected_so(input int seed, input int pass, input int b);
      logic [1:0] r;
      if (pass == 0) begin
         r = {pat_bit(prev_seed, prev_n, 1, b), pat_bit(prev_seed, prev_n, 0, b)};
      end else begin
         r = {pat_bit(seed, pass - 1, 1, (b + 2) % CHAIN_LEN),
              pat_bit(seed, pass - 1, 0, (b + 2) % CHAIN_LEN)};
      end
      return r;
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [1:0] so);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {30'h0, so};
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One run: push the expected outcome, then stream (n+1)*CHAIN_LEN beats
   task automatic applyStimulus(input int n, input int seed,
                                input int flip_pass, input int flip_chain, input int flip_beat,
                                input int stall_pass, input int stall_beat, input int stall_len,
                                input bit garbage0, input bit unmask0, input bit busy_start,
                                input int abort_pass, input int abort_beat);
      exp_t       e;
      int         k;
      int         pass;
      int         b;
      int         stall_left;
      int         budget;
      int         pre_fail;
      bit         accepted;
      bit         flip_hit;
      logic [1:0] so_ref;
      logic [31:0] sig_ref;

      sig_ref = '0;
      for (int p = 0; p <= n; p++) begin
         for (int bb = 0; bb < CHAIN_LEN; bb++) begin
            if (p == 0 && !unmask0) continue;
            sig_ref = misr_step(sig_ref, expected_so(seed, p, bb));
         end
      end
      flip_hit     = (flip_pass >= 1) && (flip_pass <= n);
      e.latency    = (n + 1) * CHAIN_LEN + n * (CAP_CYCLES + 2 * SETTLE_CYCLES) + 2
                   + (((stall_pass >= 0) && (stall_pass <= n)) ? stall_len : 0);
      e.fail_cnt   = flip_hit ? 1 : 0;
      e.first_fail = flip_hit ? flip_pass : 'hFFFF;
      e.fail_seen  = flip_hit ? 1 : 0;
      e.se_low     = n * (CAP_CYCLES + SETTLE_CYCLES);
      e.cap_cyc    = n * CAP_CYCLES;
      e.beats      = (n + 1) * CHAIN_LEN;
      e.bad_en     = 0;
      e.sig        = sig_ref;
      if (abort_pass < 0) exp_q.push_back(e);

      @(negedge clk);
      num_patterns = PAT_W'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      stall_left = stall_len;
      budget = 0;
      while (k < (n + 1) * CHAIN_LEN) begin
         pass = k / CHAIN_LEN;
         b = k % CHAIN_LEN;
         if (pass == abort_pass && b == abort_beat) begin
            pre_fail = ((flip_pass >= 1) && ((flip_pass < pass) ||
                        (flip_pass == pass && flip_beat < b))) ? 1 : 0;
            checkOutput("abort_pre_fail_cnt", fail_cnt, pre_fail);
            pat_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #2;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_test_se", test_se, 1);
            checkOutput("abort_dut_clk_en", dut_clk_en, 0);
            checkOutput("abort_fail_cnt", fail_cnt, 0);
            checkOutput("abort_fail_seen", fail_seen, 0);
            checkOutput("abort_first_fail_pat", first_fail_pat, 'hFFFF);
            checkOutput("abort_done", done, 0);
            return;
         end
         pat_valid = 1'b1;
         if (pass == stall_pass && b == stall_beat && stall_left > 0 && pat_ready) begin
            pat_valid = 1'b0;
            stall_left--;
         end
         so_ref  = expected_so(seed, pass, b);
         pat_exp = (pass == 0 && garbage0) ? ~so_ref : so_ref;
         if (pass == flip_pass && b == flip_beat) pat_exp[flip_chain] = ~pat_exp[flip_chain];
         pat_msk = (pass == 0 && !unmask0) ? 2'b00 : 2'b11;
         pat_si  = {pat_bit(seed, pass, 1, b), pat_bit(seed, pass, 0, b)};
         if (busy_start && pass == 1 && b == 20 && pat_ready) begin
            start = 1'b1;
            num_patterns = PAT_W'(5);
         end
         #4;
         accepted = pat_valid && pat_ready;
         @(negedge clk);
         start = 1'b0;
         if (accepted) k++;
         budget++;
         if (budget > 3000) begin
            checkOutput("drive_beats", k, (n + 1) * CHAIN_LEN);
            break;
         end
      end
      pat_valid = 1'b0;
      pat_msk = 2'b00;
      for (int w = 0; w < 100 && busy; w++) @(negedge clk);
      if (busy) checkOutput("run_end_busy", busy, 0);
      @(negedge clk);
      prev_seed = seed;
      prev_n = n;
   endtask

   // Monitor: track each run from its start cycle and score it on done
   int   cyc = 0;
   int   t0 = 0;
   bit   mon_active = 1'b0;
   int   se_low = 0;
   int   cap_cnt = 0;
   int   beat_cnt = 0;
   int   bad_cnt = 0;
   exp_t got_e;

   always @(negedge clk) begin
      #2;
      cyc++;
      if (reset) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && start && !busy) begin
            mon_active = 1'b1;
            t0 = cyc;
            se_low = 0;
            cap_cnt = 0;
            beat_cnt = 0;
            bad_cnt = 0;
         end
         if (mon_active) begin
            se_low   += int'(!test_se);
            cap_cnt  += int'(dut_clk_en && !test_se);
            beat_cnt += int'(pat_valid && pat_ready);
            bad_cnt  += int'(pat_ready ? (dut_clk_en != pat_valid) : (test_se && dut_clk_en));
            if (done) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_done", 1, 0);
               end else begin
                  got_e = exp_q.pop_front();
                  checkOutput("latency", cyc - t0 + 1, got_e.latency);
                  checkOutput("fail_cnt", fail_cnt, got_e.fail_cnt);
                  checkOutput("first_fail_pat", first_fail_pat, got_e.first_fail);
                  checkOutput("fail_seen", fail_seen, got_e.fail_seen);
                  checkOutput("se_low_cycles", se_low, got_e.se_low);
                  checkOutput("capture_cycles", cap_cnt, got_e.cap_cyc);
                  checkOutput("accepted_beats", beat_cnt, got_e.beats);
                  checkOutput("clk_en_misuse", bad_cnt, got_e.bad_en);
`ifdef SCAN_SIG_EN
                  checkOutput("sig", sig, got_e.sig);
`endif
               end
               mon_active = 1'b0;
            end
         end else if (done) begin
            checkOutput("unexpected_done", 1, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] reset checks");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pat_ready", pat_ready, 0);
      checkOutput("rst_test_se", test_se, 1);
      checkOutput("rst_dut_clk_en", dut_clk_en, 0);
      checkOutput("rst_test_si1", test_si1, 0);
      checkOutput("rst_test_si2", test_si2, 0);
      checkOutput("rst_fail_cnt", fail_cnt, 0);
      checkOutput("rst_fail_seen", fail_seen, 0);
      checkOutput("rst_first_fail_pat", first_fail_pat, 'hFFFF);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] clean run, 3 patterns");
      applyStimulus(3, 1, -1, 0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1, 0);
      $display("[TB] chain 2 flip at pass 2 beat 10");
      applyStimulus(3, 2, 2, 1, 10, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1, 0);
      $display("[TB] 5-cycle stall at pass 1 beat 40");
      applyStimulus(3, 3, -1, 0, 0, 1, 40, 5, 1'b0, 1'b0, 1'b0, -1, 0);
      $display("[TB] masked garbage on pass 0, start while busy");
      applyStimulus(2, 4, -1, 0, 0, -1, 0, 0, 1'b1, 1'b0, 1'b1, -1, 0);
      $display("[TB] unload-only pass");
      applyStimulus(0, 5, -1, 0, 0, -1, 0, 0, 1'b0, 1'b1, 1'b0, -1, 0);
      $display("[TB] reset mid-shift");
      applyStimulus(2, 6, 1, 0, 5, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1, 40);
      repeat (40) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
